// File: rtl/alu_word_sequencer.sv
// rtl/alu_word_sequencer.sv - multi-word sequencer driving a narrow W-bit ALU
//
// Accepts a WORDS*W-bit request over req_valid/req_ready and walks the ALU one
// word per cycle, least-significant word first. Carry/borrow is chained
// between words for OP_ADD/OP_SUB only. The assembled result and flags are
// presented on rsp_* and held until rsp_valid && rsp_ready.
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   req_valid/req_ready         request handshake
//   req_opcode/a/b/carry_in     request payload (opcode applies to every word)
//   alu_opcode/a/b/carry_in     drive the external ALU (zero outside RUN)
//   alu_output/carry_out/
//   alu_overflow/negative/zero  results from the external ALU
//   rsp_valid/rsp_ready         response handshake
//   rsp_result/carry/overflow/
//   rsp_negative/rsp_zero       assembled response
//   perf_count                  completed-response counter
//
// Optional feature macro: ALU_SEQ_PERF_EN enables perf_count; otherwise it is
// tied to 16'd0.

module alu_word_sequencer #(
  parameter int W = 4,
  parameter int WORDS = 4,
  parameter logic [W-1:0] OP_ADD = 4'd8,
  parameter logic [W-1:0] OP_SUB = 4'd9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [W-1:0]       req_opcode,
  input  logic [WORDS*W-1:0] req_a,
  input  logic [WORDS*W-1:0] req_b,
  input  logic               req_carry_in,
  output logic [W-1:0]       alu_opcode,
  output logic [W-1:0]       alu_a,
  output logic [W-1:0]       alu_b,
  output logic               alu_carry_in,
  input  logic [W-1:0]       alu_output,
  input  logic               alu_carry_out,
  input  logic               alu_overflow,
  input  logic               alu_negative,
  input  logic               alu_zero,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WORDS*W-1:0] rsp_result,
  output logic               rsp_carry,
  output logic               rsp_overflow,
  output logic               rsp_negative,
  output logic               rsp_zero,
  output logic [15:0]        perf_count
);

  localparam int N  = WORDS * W;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    opcode_q, opcode_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic            chain_q, chain_d;     // carry/borrow into the current word
  logic [IW-1:0]   idx_q, idx_d;
  logic [N-1:0]    result_q, result_d;
  logic            zero_acc_q, zero_acc_d;
  logic            carry_q, carry_d;
  logic            overflow_q, overflow_d;
  logic            zero_q, zero_d;
  logic            req_ready_q, req_ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [15:0]     perf_q, perf_d;

  logic            is_arith;
  logic            in_run;
  logic            last_word;
  logic            unused_negative;

  assign is_arith  = (opcode_q == OP_ADD) || (opcode_q == OP_SUB);
  assign in_run    = (state_q == RUN);
  assign last_word = (idx_q == IW'(WORDS - 1));

  // The response negative flag is taken from the assembled result MSB, so the
  // per-word negative from the ALU is not needed.
  assign unused_negative = alu_negative;

  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    a_d         = a_q;
    b_d         = b_q;
    chain_d     = chain_q;
    idx_d       = idx_q;
    result_d    = result_q;
    zero_acc_d  = zero_acc_q;
    carry_d     = carry_q;
    overflow_d  = overflow_q;
    zero_d      = zero_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    perf_d      = perf_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d     = RUN;
          opcode_d    = req_opcode;
          a_d         = req_a;
          b_d         = req_b;
          chain_d     = req_carry_in;
          idx_d       = '0;
          result_d    = '0;
          zero_acc_d  = 1'b1;
          carry_d     = 1'b0;
          overflow_d  = 1'b0;
          zero_d      = 1'b0;
          req_ready_d = 1'b0;
        end
      end
      RUN: begin
        result_d[idx_q*W +: W] = alu_output;
        zero_acc_d             = zero_acc_q & alu_zero;
        chain_d                = alu_carry_out;
        if (last_word) begin
          carry_d     = is_arith & alu_carry_out;
          overflow_d  = alu_overflow;
          zero_d      = zero_acc_q & alu_zero;
          rsp_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
          perf_d      = perf_q + 16'd1;
        end
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      opcode_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      chain_q     <= 1'b0;
      idx_q       <= '0;
      result_q    <= '0;
      zero_acc_q  <= 1'b0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      perf_q      <= 16'd0;
    end else begin
      state_q     <= state_d;
      opcode_q    <= opcode_d;
      a_q         <= a_d;
      b_q         <= b_d;
      chain_q     <= chain_d;
      idx_q       <= idx_d;
      result_q    <= result_d;
      zero_acc_q  <= zero_acc_d;
      carry_q     <= carry_d;
      overflow_q  <= overflow_d;
      zero_q      <= zero_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      perf_q      <= perf_d;
    end
  end

  // ALU inputs are selected straight from the latched operands; outside RUN
  // the ALU is parked at all-zero inputs.
  assign alu_opcode   = in_run ? opcode_q : '0;
  assign alu_a        = in_run ? a_q[idx_q*W +: W] : '0;
  assign alu_b        = in_run ? b_q[idx_q*W +: W] : '0;
  assign alu_carry_in = in_run & is_arith & chain_q;

  assign req_ready    = req_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_result   = result_q;
  assign rsp_carry    = carry_q;
  assign rsp_overflow = overflow_q;
  assign rsp_negative = result_q[N-1];
  assign rsp_zero     = zero_q;

`ifdef ALU_SEQ_PERF_EN
  assign perf_count = perf_q;
`else
  logic [15:0] unused_perf;
  assign unused_perf = perf_q;
  assign perf_count  = 16'd0;
`endif

endmodule

// File: tb/tb_alu_word_sequencer.sv
// tb/tb_alu_word_sequencer.sv - self-checking bench for alu_word_sequencer

module tb_alu_word_sequencer;

  localparam int W = 4;
  localparam int WORDS = 4;

  logic        clk, rst_n;
  logic        req_valid, req_ready;
  logic [3:0]  req_opcode;
  logic [15:0] req_a, req_b;
  logic        req_carry_in;
  logic [3:0]  alu_opcode, alu_a, alu_b, alu_output;
  logic        alu_carry_in, alu_carry_out, alu_overflow, alu_negative, alu_zero;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_carry, rsp_overflow, rsp_negative, rsp_zero;
  logic [15:0] perf_count;

  int vectors = 0;
  int errors  = 0;

  alu_word_sequencer #(.W(W), .WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_a(req_a), .req_b(req_b), .req_carry_in(req_carry_in),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_carry_in(alu_carry_in),
    .alu_output(alu_output), .alu_carry_out(alu_carry_out), .alu_overflow(alu_overflow),
    .alu_negative(alu_negative), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_overflow(rsp_overflow), .rsp_negative(rsp_negative),
    .rsp_zero(rsp_zero), .perf_count(perf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Narrow ALU stand-in: 8 add, 9 subtract (carry = borrow), 5/6/7 and/or/xor.
  always_comb begin
    int sa, sb, r;
    logic [4:0] s;
    sa = int'($signed(alu_a));
    sb = int'($signed(alu_b));
    r = 0;
    s = 5'd0;
    alu_output = 4'd0;
    alu_carry_out = 1'b0;
    alu_overflow = 1'b0;
    case (alu_opcode)
      4'd8: begin
        s = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_carry_in};
        r = sa + sb + int'(alu_carry_in);
        alu_output = s[3:0]; alu_carry_out = s[4]; alu_overflow = (r > 7) || (r < -8);
      end
      4'd9: begin
        s = {1'b0, alu_a} - {1'b0, alu_b} - {4'd0, alu_carry_in};
        r = sa - sb - int'(alu_carry_in);
        alu_output = s[3:0]; alu_carry_out = s[4]; alu_overflow = (r > 7) || (r < -8);
      end
      4'd5: alu_output = alu_a & alu_b;
      4'd6: alu_output = alu_a | alu_b;
      4'd7: alu_output = alu_a ^ alu_b;
      default: alu_output = 4'd0;
    endcase
    alu_negative = alu_output[3];
    alu_zero = (alu_output == 4'd0);
  end

  typedef struct {
    logic [3:0]  op;
    logic [15:0] res;
    logic        c, v, n, z;
  } exp_t;

  exp_t exp_q[$];

  // Whole-word reference: the sequenced result must equal the 16-bit operation.
  function automatic exp_t model(logic [3:0] op, logic [15:0] a, logic [15:0] b, logic cin);
    exp_t e;
    logic [16:0] s;
    int r;
    e.op = op; e.res = 16'd0; e.c = 1'b0; e.v = 1'b0;
    case (op)
      4'd8: begin
        s = {1'b0, a} + {1'b0, b} + {16'd0, cin};
        r = int'($signed(a)) + int'($signed(b)) + int'(cin);
        e.res = s[15:0]; e.c = s[16]; e.v = (r > 32767) || (r < -32768);
      end
      4'd9: begin
        s = {1'b0, a} - {1'b0, b} - {16'd0, cin};
        r = int'($signed(a)) - int'($signed(b)) - int'(cin);
        e.res = s[15:0]; e.c = s[16]; e.v = (r > 32767) || (r < -32768);
      end
      4'd5: e.res = a & b;
      4'd6: e.res = a | b;
      4'd7: e.res = a ^ b;
      default: e.res = 16'd0;
    endcase
    e.n = e.res[15];
    e.z = (e.res == 16'd0);
    return e;
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", name, got, want, $time);
    end
  endtask

  // Per-cycle compare against the reference queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      check("reset_ctrl", {30'd0, req_ready, rsp_valid}, 32'h2);
      check("reset_rsp", {11'd0, rsp_result, rsp_carry, rsp_overflow, rsp_negative, rsp_zero,
                          perf_count[0]}, 32'd0);
      check("reset_perf", {16'd0, perf_count}, 32'd0);
      check("reset_alu", {19'd0, alu_opcode, alu_a, alu_b, alu_carry_in}, 32'd0);
    end else begin
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          check("rsp_result", {16'd0, rsp_result}, {16'd0, exp_q[0].res});
          check("rsp_flags", {28'd0, rsp_carry, rsp_overflow, rsp_negative, rsp_zero},
                {28'd0, exp_q[0].c, exp_q[0].v, exp_q[0].n, exp_q[0].z});
          if (rsp_ready) void'(exp_q.pop_front());
        end
      end else if (!req_ready && exp_q.size() > 0) begin
        check("run_opcode", {28'd0, alu_opcode}, {28'd0, exp_q[0].op});
        if (exp_q[0].op != 4'd8 && exp_q[0].op != 4'd9)
          check("run_carry_in_logic", {31'd0, alu_carry_in}, 32'd0);
      end
      if (req_valid && req_ready)
        exp_q.push_back(model(req_opcode, req_a, req_b, req_carry_in));
    end
  end

  task automatic send(logic [3:0] op, logic [15:0] a, logic [15:0] b, logic cin);
    bit ok = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_opcode = op; req_a = a; req_b = b; req_carry_in = cin;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check("accept_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      n++;
      if (rsp_valid) break;
    end
    if (!rsp_valid) check("rsp_timeout", 32'd1, 32'd0);
  endtask

  task automatic run_vec(string name, logic [3:0] op, logic [15:0] a, logic [15:0] b, logic cin,
                         logic [15:0] res, logic c, logic v, logic n, logic z);
    int lat;
    send(op, a, b, cin);
    wait_rsp(lat);
    check({name, "_latency"}, lat, 32'd5);
    check({name, "_result"}, {16'd0, rsp_result}, {16'd0, res});
    check({name, "_cvnz"}, {28'd0, rsp_carry, rsp_overflow, rsp_negative, rsp_zero},
          {28'd0, c, v, n, z});
    @(posedge clk); #1;
  endtask

  int lat;

  initial begin
    rst_n = 1'b1; req_valid = 1'b0; req_opcode = 4'd0; req_a = 16'd0; req_b = 16'd0;
    req_carry_in = 1'b0; rsp_ready = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    run_vec("add_00ff", 4'd8, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0);
    run_vec("add_ffff", 4'd8, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
    run_vec("add_7fff", 4'd8, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1, 1'b0);
    run_vec("sub_1000", 4'd9, 16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b0, 1'b0);
    run_vec("sub_0000", 4'd9, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0);
    run_vec("add_cin",  4'd8, 16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0);
    run_vec("and_cin1", 4'd5, 16'hF0F0, 16'hFF00, 1'b1, 16'hF000, 1'b0, 1'b0, 1'b1, 1'b0);

    // Backpressure with a second request held during DONE.
    rsp_ready = 1'b0;
    send(4'd8, 16'h1234, 16'h1111, 1'b0);
    wait_rsp(lat);
    @(posedge clk); #1;
    req_valid = 1'b1; req_opcode = 4'd7; req_a = 16'hAAAA; req_b = 16'h0FF0; req_carry_in = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("bp_hold", {14'd0, req_ready, rsp_valid, rsp_result}, {14'd0, 1'b0, 1'b1, 16'h2345});
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_idle_after_hs", {30'd0, req_ready, rsp_valid}, 32'h2);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_rsp(lat);
    check("bp_second_latency", lat, 32'd5);
    check("bp_second_result", {16'd0, rsp_result}, 32'h0000A55A);
    @(posedge clk); #1;

    // Reset while RUN is at word index 2.
    send(4'd8, 16'h1111, 16'h2222, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_state", {14'd0, req_ready, rsp_valid, rsp_result}, {14'd0, 1'b1, 1'b0, 16'h0});
    check("abort_perf", {16'd0, perf_count}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run_vec("p1_or",  4'd6, 16'h1200, 16'h0034, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0);
    run_vec("p2_add", 4'd8, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1);
    run_vec("p3_sub", 4'd9, 16'h5555, 16'h5554, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef ALU_SEQ_PERF_EN
    check("perf_three", {16'd0, perf_count}, 32'd3);
`else
    check("perf_tied", {16'd0, perf_count}, 32'd0);
`endif

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
